// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//
// Sequences the ID/EX pipeline register and the multi-cycle FPU of the MIPS
// pipeline. It detects load-use hazards, flushes IF/ID on taken branches and
// freezes the front end while an FP instruction occupies EX.
//
// Ports
//   clk, reset        : pipeline clock, asynchronous active-high reset
//   id_ex_mem_read    : MemRead of the instruction in EX
//   id_ex_rt          : rt of the instruction in EX
//   id_ex_fp          : instruction in EX is floating-point
//   if_id_rs/if_id_rt : source registers of the instruction in ID
//   branch_taken      : branch in EX resolved taken this cycle
//   pc_write          : PC load enable
//   if_id_write       : IF/ID load enable
//   if_id_flush       : IF/ID clear to NOP
//   id_ex_hold        : ID/EX keeps its contents
//   id_ex_bubble      : ID/EX loads zeroed control fields
//   ex_mem_bubble     : EX/MEM loads zeroed control fields
//   fpu_start         : one-cycle FPU start strobe
//   fp_result_valid   : FPU result is muxed into EX/MEM this cycle
//   fp_busy           : FP sequence in progress
//   stall_count       : saturating count of cycles with pc_write low
//
// Control outputs are combinational from state and current inputs and are
// forced low while reset is asserted.

module pipeline_hazard_controller #(
    parameter int FP_LATENCY = 4,
    parameter int REG_W      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic             id_ex_fp,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_hold,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             fpu_start,
    output logic             fp_result_valid,
    output logic             fp_busy,
    output logic [15:0]      stall_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FP_BUSY = 2'd1,
        FP_DONE = 2'd2
    } state_t;

    // The start cycle and the FP_DONE cycle are not spent in FP_BUSY, so the
    // busy phase lasts FP_LATENCY-1 cycles: cnt counts FP_LATENCY-2 down to 0.
    localparam logic [3:0] CNT_INIT = 4'(FP_LATENCY - 2);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       lu;

    // Register 0 is hardwired to zero and can never carry a hazard.
    assign lu = id_ex_mem_read && (id_ex_rt != '0) &&
                ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        pc_write        = 1'b0;
        if_id_write     = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_hold      = 1'b0;
        id_ex_bubble    = 1'b0;
        ex_mem_bubble   = 1'b0;
        fpu_start       = 1'b0;
        fp_result_valid = 1'b0;
        fp_busy         = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                    end else if (id_ex_fp) begin
                        fpu_start     = 1'b1;
                        id_ex_hold    = 1'b1;
                        ex_mem_bubble = 1'b1;
                        state_nxt     = FP_BUSY;
                        cnt_nxt       = CNT_INIT;
                    end else if (lu) begin
                        id_ex_bubble = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
                FP_BUSY: begin
                    // Branches and load-use are irrelevant while EX is frozen.
                    id_ex_hold    = 1'b1;
                    ex_mem_bubble = 1'b1;
                    fp_busy       = 1'b1;
                    if (cnt != 4'd0) begin
                        cnt_nxt = cnt - 4'd1;
                    end else begin
                        state_nxt = FP_DONE;
                    end
                end
                FP_DONE: begin
                    // id_ex_fp is still high for the finishing instruction;
                    // returning to IDLE unconditionally prevents a restart.
                    fp_result_valid = 1'b1;
                    pc_write        = 1'b1;
                    if_id_write     = 1'b1;
                    fp_busy         = 1'b1;
                    state_nxt       = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= 16'd0;
        end else if (!pc_write && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  localparam int REG_W  = 6;
  localparam int FP_LAT = 4;
  localparam int VEC_W  = 25;

  // clock / reset
  logic clk;
  logic reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic             id_ex_mem_read;
  logic [REG_W-1:0] id_ex_rt;
  logic             id_ex_fp;
  logic [REG_W-1:0] if_id_rs;
  logic [REG_W-1:0] if_id_rt;
  logic             branch_taken;
  logic             pc_write, if_id_write, if_id_flush, id_ex_hold;
  logic             id_ex_bubble, ex_mem_bubble, fpu_start;
  logic             fp_result_valid, fp_busy;
  logic [15:0]      stall_count;

  pipeline_hazard_controller #(.FP_LATENCY(FP_LAT), .REG_W(REG_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_ex_mem_read  (id_ex_mem_read),
    .id_ex_rt        (id_ex_rt),
    .id_ex_fp        (id_ex_fp),
    .if_id_rs        (if_id_rs),
    .if_id_rt        (if_id_rt),
    .branch_taken    (branch_taken),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_hold      (id_ex_hold),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_bubble   (ex_mem_bubble),
    .fpu_start       (fpu_start),
    .fp_result_valid (fp_result_valid),
    .fp_busy         (fp_busy),
    .stall_count     (stall_count)
  );

  // scoreboard
  logic [VEC_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  // reference model: FP progress as "stall cycles left" plus a pending result
  int m_busy_left = 0;
  bit m_done      = 1'b0;
  int m_stall     = 0;

  // Vector layout: {pc_write, if_id_write, if_id_flush, id_ex_hold,
  // id_ex_bubble, ex_mem_bubble, fpu_start, fp_result_valid, fp_busy, stall_count}
  task automatic cyc(input logic rst, input logic mr, input logic [REG_W-1:0] ert,
                     input logic fp, input logic [REG_W-1:0] rs,
                     input logic [REG_W-1:0] rt, input logic br);
    logic [8:0] o;
    bit hz;
    @(posedge clk);
    #1;
    reset          = rst;
    id_ex_mem_read = mr;
    id_ex_rt       = ert;
    id_ex_fp       = fp;
    if_id_rs       = rs;
    if_id_rt       = rt;
    branch_taken   = br;
    o = '0;
    if (rst) begin
      m_busy_left = 0;
      m_done      = 1'b0;
      m_stall     = 0;
    end else if (m_done) begin
      o      = 9'b110_000_011;
      m_done = 1'b0;
    end else if (m_busy_left > 0) begin
      o = 9'b000_101_001;
      m_busy_left--;
      if (m_busy_left == 0) m_done = 1'b1;
    end else begin
      hz = mr && (ert != 0) && (ert == rs || ert == rt);
      if (br) o = 9'b111_010_000;
      else if (fp) begin
        o = 9'b000_101_100;
        m_busy_left = FP_LAT - 1;
      end else if (hz) o = 9'b000_010_000;
      else o = 9'b110_000_000;
    end
    exp_q.push_back({o, 16'(m_stall)});
    if (!rst && !o[8] && m_stall < 65535) m_stall++;
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0);
  endtask

  // monitor: outputs are sampled on the falling edge, mid-cycle
  initial begin
    logic [VEC_W-1:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      cyc_no++;
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        act_v = {pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_bubble,
                 ex_mem_bubble, fpu_start, fp_result_valid, fp_busy, stall_count};
        n_tests++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL cycle_%0d outputs: got %h expected %h", cyc_no, act_v, exp_v);
        end
      end
    end
  end

  // stimulus
  initial begin
    reset = 1'b1;
    id_ex_mem_read = 1'b0;
    id_ex_rt = '0;
    id_ex_fp = 1'b0;
    if_id_rs = '0;
    if_id_rt = '0;
    branch_taken = 1'b0;

    // reset held 3 cycles, then quiet release
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0);
    idle_cyc(2);

    // load-use on rs, then the bubble cycle, then the rt==0 case
    cyc(1'b0, 1'b1, 6'd5, 1'b0, 6'd5, 6'd1, 1'b0);
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 6'd5, 6'd1, 1'b0);
    cyc(1'b0, 1'b1, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0);
    cyc(1'b0, 1'b1, 6'd7, 1'b0, 6'd2, 6'd7, 1'b0);
    idle_cyc(1);

    // single FP op, id_ex_fp held through its finishing cycle
    for (int i = 0; i <= FP_LAT; i++) cyc(1'b0, 1'b0, 6'd0, 1'b1, 6'd0, 6'd0, 1'b0);
    idle_cyc(2);

    // branch and load-use together
    cyc(1'b0, 1'b1, 6'd3, 1'b0, 6'd3, 6'd0, 1'b1);
    idle_cyc(1);

    // back-to-back FP ops, with branch/lu noise while busy
    for (int i = 0; i < 2 * (FP_LAT + 1); i++)
      cyc(1'b0, 1'b1, 6'd4, 1'b1, 6'd4, 6'd0, 1'(i % 2));
    idle_cyc(1);

    // reset at T+2 of an FP operation
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 6'd0, 6'd0, 1'b0);
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 6'd0, 6'd0, 1'b0);
    cyc(1'b1, 1'b0, 6'd0, 1'b1, 6'd0, 6'd0, 1'b0);
    idle_cyc(FP_LAT + 2);

    // randomized mix
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 2) == 0),
          6'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0),
          6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
          1'($urandom_range(0, 7) == 0));

    // saturation: persistent load-use stall
    for (int i = 0; i < 65540; i++) cyc(1'b0, 1'b1, 6'd5, 1'b0, 6'd5, 6'd0, 1'b0);
    idle_cyc(3);
    cyc(1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0);
    idle_cyc(2);

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
